// File: rtl/pu_flow_pd_clr_ctl_pkg.sv
// Shared types and default sizes for the flow PD memory clear sequencer.
// FLOW_PD_CLR_MAX_STALL is also the value the memory wrapper passes down.
package pu_flow_pd_clr_ctl_pkg;

  typedef enum logic [1:0] {
    FPC_INIT  = 2'd0,
    FPC_IDLE  = 2'd1,
    FPC_CLEAR = 2'd2
  } flow_pd_clr_state_type;

  localparam int FPC_FID_NBITS         = 4;
  localparam int FPC_FLOW_PD_NBITS     = 4;
  localparam int FPC_WORDS_NBITS       = FPC_FLOW_PD_NBITS - 2;
  localparam int FPC_WIDTH_NBITS       = 64;
  localparam int FLOW_PD_CLR_MAX_STALL = 8;

endpackage

// File: rtl/pu_flow_pd_clr_ctl.sv
// Zero-fills the flow PD memory after reset and per flow on request, stealing
// idle write cycles from the PU arbiter and forcing one after MAX_STALL yields.
module pu_flow_pd_clr_ctl
  import pu_flow_pd_clr_ctl_pkg::*;
#(
  parameter int FID_NBITS   = FPC_FID_NBITS,
  parameter int WORDS_NBITS = FPC_WORDS_NBITS,
  parameter int DEPTH_NBITS = FID_NBITS + WORDS_NBITS,
  parameter int WIDTH_NBITS = FPC_WIDTH_NBITS,
  parameter int MAX_STALL   = FLOW_PD_CLR_MAX_STALL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_req,
  input  logic [FID_NBITS-1:0]   clr_fid,
  output logic                   clr_rdy,
  output logic                   clr_ack,
  output logic                   init_done,
  input  logic                   pu_wr_req,
  output logic                   pu_hold,
  output logic                   ram_wr,
  output logic [DEPTH_NBITS-1:0] ram_waddr,
  output logic [WIDTH_NBITS-1:0] ram_wdata
);

  flow_pd_clr_state_type state, state_nxt;
  logic [DEPTH_NBITS-1:0] ptr;
  logic [7:0]             stall_cnt;
  logic [FID_NBITS-1:0]   fid_r;
  logic                   active;
  logic                   starve;
  logic                   last_all;
  logic                   last_word;

  // The PU request feeds the write strobe combinationally so the memory mux
  // can switch in the same cycle.
  assign active    = (state == FPC_INIT) || (state == FPC_CLEAR);
  assign starve    = (stall_cnt == 8'(MAX_STALL));
  assign ram_wr    = active && (!pu_wr_req || starve);
  assign pu_hold   = ram_wr;
  assign clr_rdy   = (state == FPC_IDLE);
  assign last_all  = &ptr;
  assign last_word = &ptr[WORDS_NBITS-1:0];
  assign ram_waddr = (state == FPC_INIT) ? ptr : {fid_r, ptr[WORDS_NBITS-1:0]};
  assign ram_wdata = '0;

  always_comb begin
    state_nxt = state;
    case (state)
      FPC_INIT:  if (ram_wr && last_all)  state_nxt = FPC_IDLE;
      FPC_IDLE:  if (clr_req)             state_nxt = FPC_CLEAR;
      FPC_CLEAR: if (ram_wr && last_word) state_nxt = FPC_IDLE;
      default:                            state_nxt = FPC_INIT;
    endcase
  end

  // ptr wraps to 0 at the end of INIT, so CLEAR only needs the reload on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FPC_INIT;
      ptr       <= '0;
      stall_cnt <= '0;
      fid_r     <= '0;
      clr_ack   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_ack <= (state == FPC_CLEAR) && (state_nxt == FPC_IDLE);
      if ((state == FPC_INIT) && (state_nxt == FPC_IDLE))
        init_done <= 1'b1;
      if (ram_wr || (state == FPC_IDLE))
        stall_cnt <= '0;
      else if (active && pu_wr_req && !starve)
        stall_cnt <= stall_cnt + 8'd1;
      if (ram_wr)
        ptr <= ptr + DEPTH_NBITS'(1);
      if ((state == FPC_IDLE) && clr_req) begin
        fid_r <= clr_fid;
        ptr   <= '0;
      end
    end
  end

endmodule
